// File: rtl/mem_stage_sram_pkg.sv
// mem_stage_sram_pkg
//   Shared widths and the MEM-stage access FSM encoding for the SRAM-backed
//   MEM stage. Imported by the interface, the half-access engine and the top.
package mem_stage_sram_pkg;

  localparam int WORD_LEN          = 32;
  localparam int REG_FILE_ADDR_LEN = 5;
  localparam int SRAM_DATA_W       = 16;

  // One 32-bit access = lo half, then hi half, then a single DONE cycle
  // in which the pipeline is released.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } stage_state_e;

endpackage

// File: rtl/mem_stage_sram_if.sv
// mem_stage_sram_if
//   External 16-bit SRAM bus.
//   sram_addr  : half-word address (ADDR_W bits), driven by master
//   sram_wdata : write data, driven by master
//   sram_we_n  : write strobe, active-low, driven by master
//   sram_ce_n  : chip enable, active-low, driven by master
//   sram_rdata : read data, driven by the SRAM (slave)
interface mem_stage_sram_if
  import mem_stage_sram_pkg::*;
#(
  parameter int ADDR_W = 18
) ();

  logic [ADDR_W-1:0]      sram_addr;
  logic [SRAM_DATA_W-1:0] sram_wdata;
  logic [SRAM_DATA_W-1:0] sram_rdata;
  logic                   sram_we_n;
  logic                   sram_ce_n;

  modport master (
    output sram_addr, sram_wdata, sram_we_n, sram_ce_n,
    input  sram_rdata
  );

  modport slave (
    input  sram_addr, sram_wdata, sram_we_n, sram_ce_n,
    output sram_rdata
  );

endinterface

// File: rtl/mem_stage_sram_half_access.sv
// sram_half_access
//   Timing engine for one half-word SRAM access: holds chip enable for
//   WAIT_CYCLES+1 cycles and, for writes, drops the write strobe for all but
//   the last of those cycles so address/data are stable around the strobe.
//   start_i  : begin a half access in the next cycle (may coincide with last_o
//              to chain the hi half directly after the lo half)
//   write_i  : the half being started is a write (sampled with start_i)
//   busy_o   : a half access is in progress
//   last_o   : final cycle of the current half (read data valid now)
//   ce_n_o   : SRAM chip enable, active-low
//   we_n_o   : SRAM write strobe, active-low
module sram_half_access #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic write_i,
  output logic busy_o,
  output logic last_o,
  output logic ce_n_o,
  output logic we_n_o
);

  localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);

  logic             busy_q, busy_d;
  logic             write_q, write_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last;

  assign last = busy_q && (cnt_q == CNT_LAST);

  always_comb begin
    busy_d  = busy_q;
    write_d = write_q;
    cnt_d   = cnt_q;
    if (start_i) begin
      busy_d  = 1'b1;
      write_d = write_i;
      cnt_d   = '0;
    end else if (busy_q) begin
      if (last) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= 1'b0;
      write_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      busy_q  <= busy_d;
      write_q <= write_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy_o = busy_q;
  assign last_o = last;
  assign ce_n_o = !busy_q;
  // Strobe released in the last cycle so the write completes before the
  // address moves on.
  assign we_n_o = !(busy_q && write_q && !last);

endmodule

// File: rtl/mem_stage_sram.sv
// mem_stage_sram
//   MEM pipeline stage backed by a 16-bit external SRAM. Each 32-bit load or
//   store is split into a lo and a hi half-word access; upstream stages are
//   frozen while it runs. Non-memory instructions pass straight through.
//   clk, rst          : clock, synchronous active-high reset
//   wb_en_in, mem_r_en_in, mem_w_en_in, alu_res_in, st_val_in, dest_in
//                     : from EXE/MEM
//   wb_en, mem_r_en, alu_res, dest : combinational pass-through to MEM/WB
//   mem_rdata         : load data, valid from the DONE cycle until next load
//   freeze            : hold upstream registers and PC
//   sram              : SRAM bus (master side)
module mem_stage_sram
  import mem_stage_sram_pkg::*;
#(
  parameter int MEM_BASE    = 1024,
  parameter int SRAM_ADDR_W = 18,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wb_en_in,
  input  logic                         mem_r_en_in,
  input  logic                         mem_w_en_in,
  input  logic [WORD_LEN-1:0]          alu_res_in,
  input  logic [WORD_LEN-1:0]          st_val_in,
  input  logic [REG_FILE_ADDR_LEN-1:0] dest_in,
  output logic                         wb_en,
  output logic                         mem_r_en,
  output logic [WORD_LEN-1:0]          alu_res,
  output logic [REG_FILE_ADDR_LEN-1:0] dest,
  output logic [WORD_LEN-1:0]          mem_rdata,
  output logic                         freeze,
  mem_stage_sram_if.master             sram
);

  stage_state_e state_q, state_d;

  logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
  logic [SRAM_DATA_W-1:0] wdata_q, wdata_d;
  logic [SRAM_DATA_W-1:0] st_hi_q, st_hi_d;
  logic                   op_write_q, op_write_d;
  logic [WORD_LEN-1:0]    rdata_q, rdata_d;

  logic                   mem_req;
  logic [WORD_LEN-1:0]    offset;
  logic [SRAM_ADDR_W-2:0] idx_in;
  logic                   unused_offset_bits;

  logic half_start, half_write, half_busy, half_last, half_ce_n, half_we_n;

  assign mem_req = mem_r_en_in | mem_w_en_in;

  // Byte address -> word index; out-of-window addresses wrap silently.
  assign offset             = alu_res_in - WORD_LEN'(MEM_BASE);
  assign idx_in             = offset[SRAM_ADDR_W:2];
  assign unused_offset_bits = ^{offset[WORD_LEN-1:SRAM_ADDR_W+1], offset[1:0]};

  // A simultaneous read+write request is executed as a write.
  assign half_write = (state_q == ST_IDLE) ? mem_w_en_in : op_write_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    st_hi_d    = st_hi_q;
    op_write_d = op_write_q;
    rdata_d    = rdata_q;
    half_start = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (mem_req) begin
          op_write_d = mem_w_en_in;
          st_hi_d    = st_val_in[31:16];
          addr_d     = {idx_in, 1'b0};
          wdata_d    = st_val_in[15:0];
          half_start = 1'b1;
          state_d    = ST_LO;
        end
      end
      ST_LO: begin
        if (half_last) begin
          if (!op_write_q) rdata_d[15:0] = sram.sram_rdata;
          addr_d     = {addr_q[SRAM_ADDR_W-1:1], 1'b1};
          wdata_d    = st_hi_q;
          half_start = 1'b1;
          state_d    = ST_HI;
        end
      end
      ST_HI: begin
        if (half_last) begin
          if (!op_write_q) rdata_d[31:16] = sram.sram_rdata;
          state_d = ST_DONE;
        end
      end
      // Upstream advances at the end of DONE, so the request that caused
      // this access is gone by the next IDLE cycle.
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      st_hi_q    <= '0;
      op_write_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      st_hi_q    <= st_hi_d;
      op_write_q <= op_write_d;
      rdata_q    <= rdata_d;
    end
  end

  sram_half_access #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_half (
    .clk     (clk),
    .rst     (rst),
    .start_i (half_start),
    .write_i (half_write),
    .busy_o  (half_busy),
    .last_o  (half_last),
    .ce_n_o  (half_ce_n),
    .we_n_o  (half_we_n)
  );

  // Freeze rises combinationally in the IDLE cycle that sees the request so
  // the instruction is held from its very first MEM cycle.
  assign freeze = !rst && ((state_q == ST_IDLE && mem_req) ||
                           state_q == ST_LO || state_q == ST_HI);

  assign wb_en     = wb_en_in;
  assign mem_r_en  = mem_r_en_in;
  assign alu_res   = alu_res_in;
  assign dest      = dest_in;
  assign mem_rdata = rdata_q;

  assign sram.sram_addr  = addr_q;
  assign sram.sram_wdata = wdata_q;
  assign sram.sram_ce_n  = half_ce_n | !half_busy;
  assign sram.sram_we_n  = half_we_n;

endmodule
